// File: rtl/bcd_interval_timer_if.sv
// Command/config strobes and status outputs of the BCD interval timer.
// The slave modport is the timer itself; the master modport is whoever drives it.
interface bcd_interval_timer_if #(
   parameter int DIGITS = 4
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [4*DIGITS-1:0]   cfg_limit;
   logic                  cfg_reload;
   logic                  start;
   logic                  stop;
   logic                  clear;
   logic [4*DIGITS-1:0]   count;
   logic [DIGITS-1:0]     digit_en;
   logic [1:0]            state;
   logic                  running;
   logic                  done;
   logic                  cfg_err;

   modport slave (
      input  cfg_valid, cfg_limit, cfg_reload, start, stop, clear,
      output cfg_ready, count, digit_en, state, running, done, cfg_err
   );

   modport master (
      output cfg_valid, cfg_limit, cfg_reload, start, stop, clear,
      input  cfg_ready, count, digit_en, state, running, done, cfg_err
   );
endinterface

// File: rtl/bcd_interval_timer.sv
// Interval timer: prescaled tick drives a ripple-carry chain of BCD decade digits,
// compared against a configured limit for one-shot or auto-reload completion.
module bcd_interval_timer #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_interval_timer_if.slave  bus
);
   localparam int            W        = 4 * DIGITS;
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic limit_ok(input logic [W-1:0] lim);
      logic ok;
      ok = (lim != {W{1'b0}});
      for (int i = 0; i < DIGITS; i++) begin
         ok = ok && (lim[4*i +: 4] <= 4'd9);
      end
      return ok;
   endfunction

   state_t          state_q, state_d;
   logic [W-1:0]    count_q, count_d;
   logic [W-1:0]    limit_q, limit_d;
   logic            reload_q, reload_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            ready_q;
   logic            running_q;

   logic            cfg_fire_s;
   logic            advance_s;
   logic            tick_s;
   logic            carry_s;
   logic [DIGITS-1:0] en_s;
   logic [W-1:0]    inc_s;

   assign cfg_fire_s = bus.cfg_valid && ready_q;
   assign advance_s  = (state_q == RUN) && !bus.clear && !bus.stop && !cfg_fire_s;
   assign tick_s     = advance_s && (pre_q == PRE_LAST);

   // A digit steps only when the tick has rippled through every lower digit sitting at 9.
   always_comb begin
      en_s    = {DIGITS{1'b0}};
      inc_s   = count_q;
      carry_s = tick_s;
      for (int i = 0; i < DIGITS; i++) begin
         en_s[i] = carry_s;
         if (carry_s) begin
            inc_s[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : (count_q[4*i +: 4] + 4'd1);
         end else begin
            inc_s[4*i +: 4] = count_q[4*i +: 4];
         end
         carry_s = carry_s && (count_q[4*i +: 4] == 4'd9);
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      limit_d  = limit_q;
      reload_d = reload_q;
      pre_d    = pre_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      if (bus.clear) begin
         state_d = IDLE;
         count_d = {W{1'b0}};
         pre_d   = {PW{1'b0}};
      end else if (cfg_fire_s) begin
         if (limit_ok(bus.cfg_limit)) begin
            limit_d  = bus.cfg_limit;
            reload_d = bus.cfg_reload;
            count_d  = {W{1'b0}};
            pre_d    = {PW{1'b0}};
            state_d  = IDLE;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.stop) begin
         // A stop outranks start even outside RUN, so start+stop in PAUSE stays paused.
         if (state_q == RUN) begin
            state_d = PAUSE;
         end else begin
            state_d = state_q;
         end
      end else if (state_q == RUN) begin
         if (tick_s) begin
            pre_d = {PW{1'b0}};
            if (inc_s == limit_q) begin
               done_d = 1'b1;
               if (reload_q) begin
                  count_d = {W{1'b0}};
               end else begin
                  count_d = inc_s;
                  state_d = DONE;
               end
            end else begin
               count_d = inc_s;
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end else if (bus.start) begin
         case (state_q)
            IDLE: begin
               if (limit_q == {W{1'b0}}) begin
                  err_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            PAUSE: state_d = RUN;
            DONE: begin
               state_d = RUN;
               count_d = {W{1'b0}};
               pre_d   = {PW{1'b0}};
            end
            default: state_d = state_q;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= {W{1'b0}};
         limit_q   <= {W{1'b0}};
         reload_q  <= 1'b0;
         pre_q     <= {PW{1'b0}};
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b1;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         limit_q   <= limit_d;
         reload_q  <= reload_d;
         pre_q     <= pre_d;
         done_q    <= done_d;
         err_q     <= err_d;
         ready_q   <= (state_d == IDLE) || (state_d == DONE);
         running_q <= (state_d == RUN);
      end
   end

   assign bus.cfg_ready = ready_q;
   assign bus.count     = count_q;
   assign bus.digit_en  = en_s;
   assign bus.state     = state_q;
   assign bus.running   = running_q;
   assign bus.done      = done_q;
   assign bus.cfg_err   = err_q;
endmodule
